// File: rtl/conv_arbiter.sv
// rtl/conv_arbiter.sv - two-requester round-robin arbiter in front of a shared fixed/float converter
// One conversion in flight: grant, hold operands for the converter latency, then return the result to its owner.
module conv_arbiter #(
  parameter int unsigned CONV_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_target,
  input  logic [31:0] req1_target,
  input  logic [4:0]  req0_pos,
  input  logic [4:0]  req1_pos,
  input  logic        req0_op,
  input  logic        req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] cv_target,
  output logic [4:0]  cv_pos,
  output logic        cv_op,
  input  logic [31:0] cv_result,
  output logic        busy,
  output logic [15:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(CONV_LAT);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cv_target_q, cv_target_d;
  logic [4:0]  cv_pos_q, cv_pos_d;
  logic        cv_op_q, cv_op_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic        gnt0, gnt1;
  logic        rsp_hs;

  // last_q names the requester granted most recently; on a tie the other one wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    cv_target_d = cv_target_q;
    cv_pos_d    = cv_pos_q;
    cv_op_d     = cv_op_q;
    rsp_data_d  = rsp_data_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          cv_target_d = gnt1 ? req1_target : req0_target;
          cv_pos_d    = gnt1 ? req1_pos    : req0_pos;
          cv_op_d     = gnt1 ? req1_op     : req0_op;
          owner_d     = gnt1;
          last_d      = gnt1;
          cnt_d       = LAT_LOAD;
          state_d     = WAIT;
        end
      end
      // Counts LAT_LOAD..0, so WAIT spans CONV_LAT+1 cycles and samples on the last one.
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = cv_result;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      cv_target_q <= 32'd0;
      cv_pos_q    <= 5'd0;
      cv_op_q     <= 1'b0;
      rsp_data_q  <= 32'd0;
      done_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      cv_target_q <= cv_target_d;
      cv_pos_q    <= cv_pos_d;
      cv_op_q     <= cv_op_d;
      rsp_data_q  <= rsp_data_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp_data   = rsp_data_q;
  assign cv_target  = cv_target_q;
  assign cv_pos     = cv_pos_q;
  assign cv_op      = cv_op_q;
  assign busy       = (state_q != IDLE);
  assign done_cnt   = done_cnt_q;

endmodule

// File: doc/conv_arbiter.md
CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 Parameter: CONV_LAT, 1, clock edges from converter operand change to valid cv_result (range 1..15).
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: req0_valid, req1_valid  input  1 each  requester N has a conversion pending.
REQ-005 Port: req0_ready, req1_ready  output  1 each  request from requester N accepted this cycle.
REQ-006 Port: req0_target, req1_target  input  32 each  operand (fixed-point or IEEE-754 single).
REQ-007 Port: req0_pos, req1_pos  input  5 each  fixed-point binary point position.
REQ-008 Port: req0_op, req1_op  input  1 each  0 = fix-to-float, 1 = float-to-fix.
REQ-009 Port: rsp0_valid, rsp1_valid  output  1 each  result for requester N is held on rsp_data.
REQ-010 Port: rsp0_ready, rsp1_ready  input  1 each  requester N consumes its result.
REQ-011 Port: rsp_data  output  32  shared result bus.
REQ-012 Port: cv_target, cv_pos, cv_op  output  32/5/1  operands driven to the shared converter.
REQ-013 Port: cv_result  input  32  converter output, registered inside the converter.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: done_cnt  output  16  count of completed response handshakes.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP.
REQ-017 In IDLE, grant SHALL go to the only valid requester; with both valid, grant SHALL go to the requester not granted last (round-robin pointer).
REQ-018 reqN_ready SHALL be high only in IDLE for the granted requester, combinational from state, valids and pointer; acceptance = reqN_valid & reqN_ready.
REQ-019 On acceptance at edge ending cycle T: latch target/pos/op into cv_* registers, record owner, update pointer to owner, go to WAIT.
REQ-020 WAIT SHALL last exactly CONV_LAT+1 cycles (4-bit down-counter); cv_result SHALL be sampled into rsp_data at the edge ending the last WAIT cycle, then state RESP.
REQ-021 For CONV_LAT=1, rspN_valid SHALL first be high in cycle T+3.
REQ-022 cv_target/cv_pos/cv_op SHALL remain stable from T+1 until the next acceptance, including through IDLE.
REQ-023 In RESP only the owner's rspN_valid SHALL be high; rsp_data and valid SHALL hold until the owner's rspN_ready is high at a clock edge.
REQ-024 On response handshake: rspN_valid low next cycle, done_cnt increments (wraps 0xFFFF->0x0000), state IDLE.
REQ-025 No request SHALL be accepted in WAIT or RESP; both reqN_ready low.
REQ-026 rspN_ready asserted by a non-owner, or outside RESP, SHALL be ignored.
REQ-027 A requester dropping valid before acceptance SHALL not be granted; no state change occurs.
REQ-028 Minimum spacing between acceptances SHALL be CONV_LAT+3 cycles (IDLE, WAIT, RESP with immediate ready).

Reset
REQ-029 rst low SHALL asynchronously force IDLE, pointer = requester 1 (so requester 0 wins first tie), counter 0, cv_* 0, rsp_data 0, rsp0/1_valid 0, busy 0, done_cnt 0.
REQ-030 Reset mid-WAIT or mid-RESP SHALL discard the in-flight transaction with no response produced; deassertion SHALL take effect at the next rising edge.

Verification
REQ-031 Single: req0 target 0x00000300, pos 8, op 0, CONV_LAT=1, rsp0_ready high -> accept at T, rsp0_valid at T+3 with rsp_data = cv_result, done_cnt = 1.
REQ-032 Tie after reset: req0 and req1 both valid continuously -> grant order 0,1,0,1; no ready pulse during busy.
REQ-033 Backpressure: rsp1_ready low 10 cycles in RESP -> rsp1_valid and rsp_data stable 10 cycles, req0_ready low throughout, handshake on 11th.
REQ-034 Reset mid-WAIT: rst low during WAIT -> all outputs 0 immediately, no rspN_valid after release, next request served normally.
REQ-035 Latency sweep: CONV_LAT = 1, 4, 15 -> rsp_valid at T+2+CONV_LAT; cv_* stable throughout WAIT.
REQ-036 Counter wrap: preload 65535 completions -> next handshake gives done_cnt = 0x0000.
